// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM encoding
// and address-space helpers.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int WORD_BYTES     = 4;
  localparam int DEF_IMEM_WORDS = 64;
  localparam int LAST_WORD_ADDR = WORD_BYTES * DEF_IMEM_WORDS - WORD_BYTES;

  // Byte address of the highest word in a memory of the given depth.
  function automatic int last_word_addr(input int words);
    return WORD_BYTES * words - WORD_BYTES;
  endfunction

endpackage

// File: rtl/imem_loader_addr_gen.sv
// Loader address generator: latched word-aligned base, running word count,
// next write address and out-of-range flag (no wrap past the top word).
module imem_loader_addr_gen
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int AW         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic          inc_i,
  output logic [AW-1:0] base_o,
  output logic [AW-1:0] word_count_o,
  output logic [AW-1:0] addr_o,
  output logic          oob_o
);

  logic [AW-1:0] base_q;
  logic [AW-1:0] wc_q;
  logic [AW+1:0] sum;

  // Two extra bits so an address past the top of memory is seen, not wrapped.
  assign sum          = {2'b00, base_q} + {wc_q, 2'b00};
  assign addr_o       = sum[AW-1:0];
  assign oob_o        = sum > (AW+2)'(last_word_addr(IMEM_WORDS));
  assign base_o       = base_q;
  assign word_count_o = wc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      wc_q   <= '0;
    end else if (load_i) begin
      base_q <= base_i & ~AW'(WORD_BYTES - 1);
      wc_q   <= '0;
    end else if (inc_i) begin
      wc_q   <= wc_q + AW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader for SingleCycleProc instruction memory: streams words in,
// holds the core in reset, then releases it at startPC. Option: LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS  = DEF_IMEM_WORDS,
  parameter int AW          = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          Reset_L,
  input  logic          load_start,
  input  logic [AW-1:0] base_addr,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          proc_Reset_L,
  output logic [31:0]   startPC,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] word_count,
  output logic [2:0]    dbg_state
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  state_t          state_q, state_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            start, accept, write;
  logic [AW-1:0]   base, next_addr;
  logic            oob;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     sum_q;
`endif

  imem_loader_addr_gen #(.IMEM_WORDS(IMEM_WORDS), .AW(AW)) u_addr_gen (
    .clk          (CLK),
    .rst_n        (Reset_L),
    .load_i       (start),
    .base_i       (base_addr),
    .inc_i        (write),
    .base_o       (base),
    .word_count_o (word_count),
    .addr_o       (next_addr),
    .oob_o        (oob)
  );

  // Stream handshake: a beat transfers on a cycle where ld_valid && ld_ready;
  // ld_ready depends only on state, never on ld_valid.
  assign ld_ready = (state_q == ST_LOAD);
  assign accept   = ld_valid && ld_ready;
  assign start    = load_start &&
                    (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR);

  always_comb begin
    state_d    = state_q;
    write      = 1'b0;
    hold_cnt_d = (state_q == ST_HOLD) ? hold_cnt_q + HCW'(1) : '0;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (ld_last)  state_d = (sum_q == ld_data) ? ST_HOLD : ST_ERR;
          else if (oob) state_d = ST_ERR;
          else          write   = 1'b1;
`else
          if (oob) begin
            state_d = ST_ERR;
          end else begin
            write = 1'b1;
            if (ld_last) state_d = ST_HOLD;
          end
`endif
        end
      end
      ST_HOLD: if (hold_cnt_q == HCW'(HOLD_CYCLES)) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      we_q       <= write;
      if (write) begin
        addr_q  <= next_addr;
        wdata_q <= ld_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)   sum_q <= '0;
    else if (start) sum_q <= '0;
    else if (write) sum_q <= sum_q + ld_data;
  end
`endif

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign proc_Reset_L = (state_q == ST_RUN);
  assign done         = (state_q == ST_RUN);
  assign err          = (state_q == ST_ERR);
  assign startPC      = {{(32-AW){1'b0}}, base};
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, streaming loads, hold timing,
// reload from RUN, bound error and optional checksum sessions.
module tb_imem_loader;

  logic        CLK;
  logic        Reset_L;
  logic        load_start;
  logic [7:0]  base_addr;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        proc_Reset_L;
  logic [31:0] startPC;
  logic        done;
  logic        err;
  logic [7:0]  word_count;
  logic [2:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [39:0] exp_q[$];

  imem_loader dut (
    .CLK          (CLK),
    .Reset_L      (Reset_L),
    .load_start   (load_start),
    .base_addr    (base_addr),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .proc_Reset_L (proc_Reset_L),
    .startPC      (startPC),
    .done         (done),
    .err          (err),
    .word_count   (word_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load(input logic [7:0] b);
    base_addr  = b;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input int gap,
                           input logic wr, input logic [7:0] a);
    if (wr) exp_q.push_back({a, d});
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic wait_run(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      tick();
    end
    check(tag, {31'b0, done}, 32'd1);
  endtask

  // scoreboard: every write must match the head of the expected queue
  always begin
    @(posedge CLK);
    #2;
    if (Reset_L && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {24'b0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'b0, imem_addr}, {24'b0, e[39:32]});
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    Reset_L = 1'b0; load_start = 1'b0; base_addr = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_we",    {31'b0, imem_we},      32'd0);
    check("rst_addr",  {24'b0, imem_addr},    32'd0);
    check("rst_wdata", imem_wdata,            32'd0);
    check("rst_prst",  {31'b0, proc_Reset_L}, 32'd0);
    check("rst_pc",    startPC,               32'd0);
    check("rst_done",  {31'b0, done},         32'd0);
    check("rst_err",   {31'b0, err},          32'd0);
    check("rst_wc",    {24'b0, word_count},   32'd0);
    check("rst_ready", {31'b0, ld_ready},     32'd0);
    check("rst_state", {29'b0, dbg_state},    32'd0);
    Reset_L = 1'b1;
    tick();

    // reset in the middle of a load
    start_load(8'h40);
    send_beat(32'h0000_0011, 1'b0, 0, 1'b1, 8'h40);
    send_beat(32'h0000_0022, 1'b0, 0, 1'b1, 8'h44);
    send_beat(32'h0000_0033, 1'b0, 0, 1'b1, 8'h48);
    tick();
    check("mid_wc3", {24'b0, word_count}, 32'd3);
    Reset_L = 1'b0;
    #1;
    check("mid_we",    {31'b0, imem_we},   32'd0);
    check("mid_addr",  {24'b0, imem_addr}, 32'd0);
    check("mid_wc",    {24'b0, word_count},32'd0);
    check("mid_pc",    startPC,            32'd0);
    check("mid_state", {29'b0, dbg_state}, 32'd0);
    tick();
    Reset_L = 1'b1;
    tick();
    check("mid_expq", exp_q.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    start_load(8'h00);
    send_beat(32'd1, 1'b0, 0, 1'b1, 8'h00);
    send_beat(32'd2, 1'b0, 0, 1'b1, 8'h04);
    send_beat(32'd3, 1'b0, 0, 1'b1, 8'h08);
    send_beat(32'd6, 1'b1, 0, 1'b0, 8'h00);
    wait_run("cks_ok_done");
    check("cks_ok_wc",   {24'b0, word_count},   32'd3);
    check("cks_ok_prst", {31'b0, proc_Reset_L}, 32'd1);
    start_load(8'h00);
    send_beat(32'd1, 1'b0, 0, 1'b1, 8'h00);
    send_beat(32'd2, 1'b0, 0, 1'b1, 8'h04);
    send_beat(32'd3, 1'b0, 0, 1'b1, 8'h08);
    send_beat(32'd7, 1'b1, 0, 1'b0, 8'h00);
    check("cks_bad_err",  {31'b0, err},          32'd1);
    check("cks_bad_wc",   {24'b0, word_count},   32'd3);
    check("cks_bad_prst", {31'b0, proc_Reset_L}, 32'd0);
`else
    // load_start beats a simultaneous ld_valid in IDLE
    base_addr  = 8'h00;
    ld_valid   = 1'b1;
    ld_data    = 32'hDEAD_BEEF;
    load_start = 1'b1;
    #1;
    check("idle_ready", {31'b0, ld_ready}, 32'd0);
    tick();
    load_start = 1'b0;
    ld_valid   = 1'b0;
    check("b_ready", {31'b0, ld_ready},     32'd1);
    check("b_prst",  {31'b0, proc_Reset_L}, 32'd0);
    check("b_state", {29'b0, dbg_state},    32'd1);
    send_beat(32'h2001_0005, 1'b0, 0, 1'b1, 8'h00);
    send_beat(32'h2002_0003, 1'b0, 0, 1'b1, 8'h04);
    send_beat(32'h0022_1820, 1'b0, 0, 1'b1, 8'h08);
    send_beat(32'hAC03_0000, 1'b1, 0, 1'b1, 8'h0C);
    check("b_hold0", {31'b0, proc_Reset_L}, 32'd0);
    check("b_hstate", {29'b0, dbg_state},   32'd2);
    tick();
    check("b_hold1", {31'b0, proc_Reset_L}, 32'd0);
    tick();
    check("b_hold2", {31'b0, proc_Reset_L}, 32'd0);
    tick();
    check("b_rise",  {31'b0, proc_Reset_L}, 32'd1);
    check("b_done",  {31'b0, done},         32'd1);
    check("b_pc",    startPC,               32'd0);
    check("b_wc",    {24'b0, word_count},   32'd4);

    // reload from RUN
    start_load(8'hA0);
    check("d_prst", {31'b0, proc_Reset_L}, 32'd0);
    check("d_done", {31'b0, done},         32'd0);
    check("d_wc0",  {24'b0, word_count},   32'd0);
    send_beat(32'h1234_5678, 1'b0, 0, 1'b1, 8'hA0);
    send_beat(32'h9ABC_DEF0, 1'b1, 0, 1'b1, 8'hA4);
    wait_run("d_run");
    check("d_pc", startPC,             32'h0000_00A0);
    check("d_wc", {24'b0, word_count}, 32'd2);

    // unaligned base with gaps; load_start ignored in LOAD
    start_load(8'h62);
    check("c_pc", startPC, 32'h0000_0060);
    send_beat(32'hAAAA_0001, 1'b0, 2, 1'b1, 8'h60);
    check("c_gap_we", {31'b0, imem_we}, 32'd0);
    base_addr  = 8'h10;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("c_ign_pc",    startPC,             32'h0000_0060);
    check("c_ign_wc",    {24'b0, word_count}, 32'd1);
    check("c_ign_state", {29'b0, dbg_state},  32'd1);
    send_beat(32'hAAAA_0002, 1'b0, 1, 1'b1, 8'h64);
    send_beat(32'hAAAA_0003, 1'b1, 0, 1'b1, 8'h68);
    wait_run("c_run");
    check("c_pc_run", startPC,             32'h0000_0060);
    check("c_wc",     {24'b0, word_count}, 32'd3);

    // running off the top of memory
    start_load(8'hF8);
    send_beat(32'hBBBB_0001, 1'b0, 0, 1'b1, 8'hF8);
    send_beat(32'hBBBB_0002, 1'b0, 0, 1'b1, 8'hFC);
    send_beat(32'hBBBB_0003, 1'b1, 0, 1'b0, 8'h00);
    check("e_err",   {31'b0, err},          32'd1);
    check("e_prst",  {31'b0, proc_Reset_L}, 32'd0);
    check("e_we",    {31'b0, imem_we},      32'd0);
    check("e_wc",    {24'b0, word_count},   32'd2);
    check("e_state", {29'b0, dbg_state},    32'd4);
    repeat (3) tick();
    check("e_err_hold", {31'b0, err},      32'd1);
    check("e_ready",    {31'b0, ld_ready}, 32'd0);
`endif
    tick();
    check("final_expq", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
